z80_bus_arbiter: RTL and testbench
==================================

Name: z80_bus_arbiter

Overview:
- Shares the Z80 core's external memory/IO bus between the CPU and one DMA-style requester (blitter, disk/SD engine).
- Generates the CPU clock enable and drives the core's bus-request input.
- Grants the bus to the requester only after the core acknowledges, meters the burst length, and enforces a CPU-time fairness window between bursts.
- Sits between the Z80 core instance and the system bus multiplexer.

Parameters:
- CEN_DIV, 2: clk cycles per cpu_cen pulse (legal range 1..16).
- MAX_BURST, 16: maximum dma_strobe accesses per grant (legal range 1..255).
- MIN_CPU_CEN, 4: cpu_cen pulses the CPU must receive after a release before the next request (legal range 0..255).
- TIMEOUT, 64: clk cycles allowed for busak assertion; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_cen  out  1  single-clk clock-enable pulse to the Z80 core
- cpu_busrq_n  out  1  bus request to the core (active low)
- cpu_busak_n  in  1  bus acknowledge from the core (active low)
- dma_req  in  1  requester wants the bus; level-held
- dma_strobe  in  1  one bus access completed by the requester; valid only while dma_gnt=1
- dma_last  in  1  qualifies dma_strobe: requester is finished
- dma_gnt  out  1  requester owns the bus
- bus_sel  out  1  bus mux select: 0 = CPU, 1 = DMA
- timeout_err  out  1  sticky error flag; constant 0 without the optional feature

Behaviour:
- Reset values: cpu_cen=0, cpu_busrq_n=1, dma_gnt=0, bus_sel=0, timeout_err=0, state=IDLE, all counters 0.
- Reset is honoured in any state. Mid-grant, dma_gnt and bus_sel drop immediately; the requester must tolerate the abort.
- cpu_cen:
  - Divider counts 0..CEN_DIV-1; cpu_cen=1 in the cycle the count equals CEN_DIV-1.
  - With CEN_DIV=1, cpu_cen is constantly 1 after reset.
  - Free-running in all states; the core needs enables to sample BUSRQ and to release the bus.
- cpu_busak_n is passed through a 2-flop synchroniser (sync_busak) before use.
- IDLE: if dma_req=1 and fair_cnt=0, go to REQ and drive cpu_busrq_n=0 (registered, one clk after entry decision).
- REQ: cpu_busrq_n=0. When sync_busak=0, go to GRANT with dma_gnt=1, bus_sel=1 from the next cycle; load burst_cnt=MAX_BURST.
- REQ with dma_req dropped before acknowledge: go to RELEASE. No grant is issued.
- GRANT:
  - Each dma_strobe decrements burst_cnt.
  - Go to RELEASE on any of: dma_strobe with dma_last=1; dma_strobe with burst_cnt=1; dma_req=0.
  - On the transition, dma_gnt and bus_sel drop in the same registered update.
- RELEASE: cpu_busrq_n=1. Wait for sync_busak=1, then go to IDLE and load fair_cnt=MIN_CPU_CEN.
- fair_cnt:
  - Decrements on each cpu_cen while in IDLE; saturates at 0.
  - dma_req arriving while fair_cnt>0 is held off; no request is issued until it reaches 0.
- Simultaneous dma_strobe and dma_req=0 in GRANT: the strobe counts, and the state still goes to RELEASE.
- dma_strobe outside GRANT is ignored.
- Invariant: bus_sel=1 only while sync_busak=0 has been observed and cpu_busrq_n=0 in the preceding cycle.

Optional Feature:
- Macro: Z80_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ and RELEASE.
  - If TIMEOUT clk cycles elapse without the awaited sync_busak transition, timeout_err is set (sticky until reset).
  - REQ times out to IDLE with cpu_busrq_n=1 and fair_cnt loaded.
  - RELEASE times out to IDLE with bus_sel forced 0.
- Not defined: no timeout counter, REQ/RELEASE wait indefinitely, timeout_err tied to 0.

Test Plan:
- Reset, CEN_DIV=2: cpu_cen pulses every 2nd clk starting 2 clks after reset release; cpu_busrq_n=1, bus_sel=0 throughout with dma_req=0.
- Basic grant:
  - Stimulus: dma_req=1; core model asserts busak_n=0 3 clks after busrq_n falls.
  - Response: dma_gnt=1 exactly 3 clks after busak_n falls (2 sync + 1 register).
  - 5 strobes with dma_last on the 5th: dma_gnt=0 the next clk, busrq_n=1.
- Burst cap, MAX_BURST=16: requester strobes 20 times without dma_last; grant drops after the 16th strobe; next request is blocked until 4 cpu_cen pulses have occurred in IDLE.
- Withdrawal: dma_req drops in REQ before busak; no dma_gnt pulse ever; busrq_n returns to 1 and FSM returns to IDLE once busak_n=1.
- Reset mid-GRANT after 3 strobes: dma_gnt, bus_sel and cpu_busrq_n take reset values in the same cycle reset_n falls; after release the arbiter restarts from IDLE.
- With Z80_ARB_TIMEOUT_EN, TIMEOUT=64, core never acknowledges: timeout_err=1 at cycle 64 of REQ; cpu_busrq_n=1 and dma_gnt stays 0.

Source files
------------

// File: rtl/z80_bus_arbiter_if.sv
// rtl/z80_bus_arbiter_if.sv - Z80 core / DMA requester bus-sharing signals
// master: arbiter side; slave: core + requester side.
interface z80_bus_arbiter_if;
  logic cpu_cen;
  logic cpu_busrq_n;
  logic cpu_busak_n;
  logic dma_req;
  logic dma_strobe;
  logic dma_last;
  logic dma_gnt;
  logic bus_sel;
  logic timeout_err;

  modport master (
    output cpu_cen, cpu_busrq_n, dma_gnt, bus_sel, timeout_err,
    input  cpu_busak_n, dma_req, dma_strobe, dma_last
  );

  modport slave (
    input  cpu_cen, cpu_busrq_n, dma_gnt, bus_sel, timeout_err,
    output cpu_busak_n, dma_req, dma_strobe, dma_last
  );
endinterface

// File: rtl/z80_bus_arbiter.sv
// rtl/z80_bus_arbiter.sv - Z80 bus sharing between CPU and one DMA requester
// Optional busak timeout watchdog: Z80_ARB_TIMEOUT_EN.
module z80_bus_arbiter #(
  parameter int CEN_DIV     = 2,
  parameter int MAX_BURST   = 16,
  parameter int MIN_CPU_CEN = 4,
  parameter int TIMEOUT     = 64
) (
  input logic              clk,
  input logic              reset_n,
  z80_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GRANT, S_RELEASE} state_t;

  localparam logic [4:0] CEN_LAST  = 5'(CEN_DIV - 1);
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);
  localparam logic [7:0] FAIR_MAX  = 8'(MIN_CPU_CEN);

  state_t     r_state;
  logic [4:0] r_cen_cnt;
  logic       r_cen;
  logic       r_busak_meta;
  logic       r_busak_sync;
  logic       r_busrq_n;
  logic       r_gnt;
  logic       r_bus_sel;
  logic [7:0] r_burst_cnt;
  logic [7:0] r_fair_cnt;
  logic       w_grant_end;

  assign w_grant_end = !bus.dma_req ||
                       (bus.dma_strobe && (bus.dma_last || r_burst_cnt == 8'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cen_cnt <= '0;
      r_cen     <= 1'b0;
    end else begin
      r_cen_cnt <= (r_cen_cnt == CEN_LAST) ? 5'd0 : r_cen_cnt + 5'd1;
      r_cen     <= (r_cen_cnt == CEN_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busak_meta <= 1'b1;
      r_busak_sync <= 1'b1;
    end else begin
      r_busak_meta <= bus.cpu_busak_n;
      r_busak_sync <= r_busak_meta;
    end
  end

`ifdef Z80_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] r_to_cnt;
  logic        r_timeout_err;
  assign bus.timeout_err = r_timeout_err;
`else
  // Watchdog not built; the comparison keeps TIMEOUT referenced and is always 0.
  assign bus.timeout_err = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_busrq_n   <= 1'b1;
      r_gnt       <= 1'b0;
      r_bus_sel   <= 1'b0;
      r_burst_cnt <= '0;
      r_fair_cnt  <= '0;
`ifdef Z80_ARB_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
`ifdef Z80_ARB_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
          if (bus.dma_req && r_fair_cnt == 8'd0) begin
            r_state   <= S_REQ;
            r_busrq_n <= 1'b0;
          end else if (r_cen && r_fair_cnt != 8'd0) begin
            r_fair_cnt <= r_fair_cnt - 8'd1;
          end
        end
        S_REQ: begin
          if (!bus.dma_req) begin
            r_state   <= S_RELEASE;
            r_busrq_n <= 1'b1;
`ifdef Z80_ARB_TIMEOUT_EN
            r_to_cnt  <= '0;
`endif
          end else if (!r_busak_sync) begin
            r_state     <= S_GRANT;
            r_gnt       <= 1'b1;
            r_bus_sel   <= 1'b1;
            r_burst_cnt <= BURST_MAX;
`ifdef Z80_ARB_TIMEOUT_EN
            r_to_cnt    <= '0;
          end else if (r_to_cnt == TO_LAST) begin
            r_state       <= S_IDLE;
            r_busrq_n     <= 1'b1;
            r_fair_cnt    <= FAIR_MAX;
            r_timeout_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
`endif
          end
        end
        S_GRANT: begin
          if (bus.dma_strobe) begin
            r_burst_cnt <= r_burst_cnt - 8'd1;
          end
          // Grant and mux select fall together with the request release.
          if (w_grant_end) begin
            r_state   <= S_RELEASE;
            r_gnt     <= 1'b0;
            r_bus_sel <= 1'b0;
            r_busrq_n <= 1'b1;
          end
        end
        S_RELEASE: begin
          r_busrq_n <= 1'b1;
          if (r_busak_sync) begin
            r_state    <= S_IDLE;
            r_fair_cnt <= FAIR_MAX;
`ifdef Z80_ARB_TIMEOUT_EN
          end else if (r_to_cnt == TO_LAST) begin
            r_state       <= S_IDLE;
            r_bus_sel     <= 1'b0;
            r_fair_cnt    <= FAIR_MAX;
            r_timeout_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_cen     = r_cen;
  assign bus.cpu_busrq_n = r_busrq_n;
  assign bus.dma_gnt     = r_gnt;
  assign bus.bus_sel     = r_bus_sel;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// tb/tb_z80_bus_arbiter.sv - directed bench for z80_bus_arbiter
// Core acknowledge and requester are driven by hand from the stimulus sequence.
module tb_z80_bus_arbiter;

  logic clk;
  logic reset_n;
  int   n_pass;
  int   n_checks;

  z80_bus_arbiter_if bus_if ();

  z80_bus_arbiter #(
    .CEN_DIV     (2),
    .MAX_BURST   (16),
    .MIN_CPU_CEN (4),
    .TIMEOUT     (64)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busrq_low(input string tag);
    int i;
    for (i = 0; i < 200 && bus_if.cpu_busrq_n !== 1'b0; i++) step();
    check(tag, (bus_if.cpu_busrq_n === 1'b0), 1);
  endtask

  initial begin
    int cnt;
    logic bad;
    clk = 0;
    reset_n = 0;
    n_pass = 0;
    n_checks = 0;
    bus_if.dma_req = 0;
    bus_if.dma_strobe = 0;
    bus_if.dma_last = 0;
    bus_if.cpu_busak_n = 1;

    repeat (3) step();
    check("rst_cen", bus_if.cpu_cen, 0);
    check("rst_busrq_n", bus_if.cpu_busrq_n, 1);
    check("rst_gnt", bus_if.dma_gnt, 0);
    check("rst_bus_sel", bus_if.bus_sel, 0);
    check("rst_timeout_err", bus_if.timeout_err, 0);

    // cpu_cen high after the 2nd, 4th, ... edge following release
    reset_n = 1;
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("cen_cycle%0d", k), bus_if.cpu_cen, (k % 2 == 0));
      if (bus_if.cpu_busrq_n !== 1'b1 || bus_if.bus_sel !== 1'b0) bad = 1;
    end
    check("idle_busrq_sel", bad, 0);

    // Basic grant: ack 3 clks after busrq falls, grant 3 clks after ack
    bus_if.dma_req = 1;
    step();
    check("basic_busrq_fall", bus_if.cpu_busrq_n, 0);
    repeat (3) step();
    bus_if.cpu_busak_n = 0;
    step();
    check("basic_gnt_sync1", bus_if.dma_gnt, 0);
    step();
    check("basic_gnt_sync2", bus_if.dma_gnt, 0);
    step();
    check("basic_gnt_on", bus_if.dma_gnt, 1);
    check("basic_sel_on", bus_if.bus_sel, 1);
    for (int i = 1; i <= 5; i++) begin
      bus_if.dma_strobe = 1;
      bus_if.dma_last = (i == 5);
      step();
      check($sformatf("basic_gnt_strobe%0d", i), bus_if.dma_gnt, (i < 5));
    end
    bus_if.dma_strobe = 0;
    bus_if.dma_last = 0;
    bus_if.dma_req = 0;
    check("basic_busrq_release", bus_if.cpu_busrq_n, 1);
    check("basic_sel_off", bus_if.bus_sel, 0);
    step();
    bus_if.cpu_busak_n = 1;
    repeat (20) step();

    // Burst cap at 16 strobes, then fairness window of 4 cpu_cen
    bus_if.dma_req = 1;
    wait_busrq_low("burst_busrq_wait");
    repeat (3) step();
    bus_if.cpu_busak_n = 0;
    repeat (3) step();
    check("burst_gnt_on", bus_if.dma_gnt, 1);
    bus_if.dma_strobe = 1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 15 || i == 16 || i == 20)
        check($sformatf("burst_gnt_strobe%0d", i), bus_if.dma_gnt, (i < 16));
      if (i == 16) check("burst_busrq_release", bus_if.cpu_busrq_n, 1);
    end
    bus_if.dma_strobe = 0;
    bus_if.cpu_busak_n = 1;
    repeat (3) step();
    cnt = 0;
    for (int i = 0; i < 100 && bus_if.cpu_busrq_n === 1'b1; i++) begin
      if (bus_if.cpu_cen === 1'b1) cnt++;
      step();
    end
    check("fair_busrq_rerequest", bus_if.cpu_busrq_n, 0);
    check("fair_cen_count", cnt, 4);

    // Withdrawal in REQ before acknowledge
    bus_if.dma_req = 0;
    step();
    check("withdraw_busrq", bus_if.cpu_busrq_n, 1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus_if.dma_gnt !== 1'b0 || bus_if.bus_sel !== 1'b0) bad = 1;
      step();
    end
    check("withdraw_no_grant", bad, 0);

    // Re-request proves return to IDLE; then reset mid-grant
    bus_if.dma_req = 1;
    wait_busrq_low("reset_busrq_wait");
    repeat (3) step();
    bus_if.cpu_busak_n = 0;
    repeat (3) step();
    check("reset_gnt_on", bus_if.dma_gnt, 1);
    bus_if.dma_strobe = 1;
    repeat (3) step();
    bus_if.dma_strobe = 0;
    check("reset_gnt_after3", bus_if.dma_gnt, 1);
    reset_n = 0;
    #1;
    check("abort_gnt", bus_if.dma_gnt, 0);
    check("abort_sel", bus_if.bus_sel, 0);
    check("abort_busrq_n", bus_if.cpu_busrq_n, 1);
    check("abort_cen", bus_if.cpu_cen, 0);
    bus_if.cpu_busak_n = 1;
    step();
    step();
    reset_n = 1;
    step();
    check("restart_busrq_n", bus_if.cpu_busrq_n, 0);
    bus_if.cpu_busak_n = 0;
    repeat (3) step();
    check("restart_gnt_on", bus_if.dma_gnt, 1);
    bus_if.dma_strobe = 1;
    bus_if.dma_last = 1;
    step();
    bus_if.dma_strobe = 0;
    bus_if.dma_last = 0;
    bus_if.dma_req = 0;
    check("restart_gnt_off", bus_if.dma_gnt, 0);
    bus_if.cpu_busak_n = 1;
    repeat (30) step();

`ifdef Z80_ARB_TIMEOUT_EN
    bus_if.dma_req = 1;
    wait_busrq_low("to_busrq_wait");
    repeat (63) step();
    check("to_err_cycle63", bus_if.timeout_err, 0);
    step();
    check("to_err_cycle64", bus_if.timeout_err, 1);
    check("to_busrq_n", bus_if.cpu_busrq_n, 1);
    check("to_gnt", bus_if.dma_gnt, 0);
    bus_if.dma_req = 0;
    repeat (10) step();
    check("to_err_sticky", bus_if.timeout_err, 1);
`else
    check("timeout_err_tied", bus_if.timeout_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
